muldiv_unit_mq: RTL and testbench

//  Multi-hart, queued RV32M multiply/divide coprocessor. Successor to the single-slot muldiv unit.

---
 rtl/muldiv_unit_mq.sv | 259 +++++++++++++++++++++++++
 tb/tb_muldiv_unit_mq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_mq.sv
// muldiv_unit_mq: queued, multi-hart RV32M multiply/divide coprocessor.
// Requests from any hart are buffered in a small FIFO and executed in order by
// a multi-cycle multiplier and a radix-2 restoring divider. A per-hart kill
// invalidates queued work of that hart and aborts its in-flight operation.
//
// Handshake: a request is accepted on any rising edge where muldiv_start=1 and
// muldiv_busy=0 (busy is a pure function of the registered FIFO count, so a pop
// in the same cycle never makes room for a start). Results are presented with a
// single-cycle muldiv_done pulse; the consumer must always accept them.
module muldiv_unit_mq #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 1,
  parameter int REG_ADDR_W = 5,
  parameter int QDEPTH     = 4,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  input  logic                  muldiv_kill,
  input  logic [HART_ID_W-1:0]  muldiv_kill_hart_id,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [2:0]            fifo_op_q   [QDEPTH];
  logic [XLEN-1:0]       fifo_a_q    [QDEPTH];
  logic [XLEN-1:0]       fifo_b_q    [QDEPTH];
  logic [HART_ID_W-1:0]  fifo_hart_q [QDEPTH];
  logic [REG_ADDR_W-1:0] fifo_rd_q   [QDEPTH];
  logic                  fifo_vld_q  [QDEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]        count_q;

  logic push, pop, fifo_empty;

  assign muldiv_busy = (count_q == (PTR_W+1)'(QDEPTH));
  assign push        = muldiv_start && !muldiv_busy;
  assign fifo_empty  = (count_q == '0);

  // FIFO storage, pointers and count; kill clears valid bits, a same-cycle push still lands valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_op_q[i]   <= '0;
        fifo_a_q[i]    <= '0;
        fifo_b_q[i]    <= '0;
        fifo_hart_q[i] <= '0;
        fifo_rd_q[i]   <= '0;
        fifo_vld_q[i]  <= 1'b0;
      end
    end else begin
      if (muldiv_kill) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (fifo_hart_q[i] == muldiv_kill_hart_id) fifo_vld_q[i] <= 1'b0;
        end
      end
      if (push) begin
        fifo_op_q[wr_ptr_q]   <= muldiv_op;
        fifo_a_q[wr_ptr_q]    <= muldiv_a;
        fifo_b_q[wr_ptr_q]    <= muldiv_b;
        fifo_hart_q[wr_ptr_q] <= muldiv_hart_id;
        fifo_rd_q[wr_ptr_q]   <= muldiv_rd;
        fifo_vld_q[wr_ptr_q]  <= 1'b1;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head-of-queue view and issue-time decode
  logic [2:0]            h_op;
  logic [XLEN-1:0]       h_a, h_b, h_a_abs, h_b_abs, h_spec_res;
  logic [HART_ID_W-1:0]  h_hart;
  logic [REG_ADDR_W-1:0] h_rd;
  logic                  h_ok, h_signed_div, h_special;

  assign h_op   = fifo_op_q[rd_ptr_q];
  assign h_a    = fifo_a_q[rd_ptr_q];
  assign h_b    = fifo_b_q[rd_ptr_q];
  assign h_hart = fifo_hart_q[rd_ptr_q];
  assign h_rd   = fifo_rd_q[rd_ptr_q];
  // An entry killed in this very cycle is treated as already invalid.
  assign h_ok   = fifo_vld_q[rd_ptr_q] &&
                  !(muldiv_kill && (h_hart == muldiv_kill_hart_id));

  // DIV/REM are the signed divide ops (funct3 bit 0 clear).
  assign h_signed_div = !h_op[0];
  assign h_special    = h_op[2] &&
                        ((h_b == '0) || (h_signed_div && (h_a == MIN_NEG) && (h_b == ALL_ONE)));
  // Divide-by-zero: quotient all-ones, remainder = dividend; overflow: quotient MIN, remainder 0.
  assign h_spec_res   = (h_b == '0) ? (h_op[1] ? h_a : ALL_ONE)
                                    : (h_op[1] ? '0  : MIN_NEG);
  assign h_a_abs      = (h_signed_div && h_a[XLEN-1]) ? (XLEN'(0) - h_a) : h_a;
  assign h_b_abs      = (h_signed_div && h_b[XLEN-1]) ? (XLEN'(0) - h_b) : h_b;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            cur_op_q;
  logic [HART_ID_W-1:0]  cur_hart_q;
  logic [REG_ADDR_W-1:0] cur_rd_q;
  logic                  latch, kill_cur, mul_last, div_last;

  assign kill_cur = muldiv_kill && (cur_hart_q == muldiv_kill_hart_id);
  assign mul_last = (state_q == ST_MUL) && (cnt_q == CNT_W'(MUL_LAT - 1));
  assign div_last = (state_q == ST_DIV) && (cnt_q == CNT_W'(XLEN - 1));

  // Next-state and pop decision; invalid heads are dropped in IDLE without leaving it
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (h_ok) begin
            latch = 1'b1;
            if (!h_op[2])       state_d = ST_MUL;
            else if (h_special) state_d = ST_DONE;
            else                state_d = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (kill_cur)      state_d = ST_IDLE;
        else if (mul_last) state_d = ST_DONE;
      end
      ST_DIV: begin
        if (kill_cur)      state_d = ST_IDLE;
        else if (div_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]   opa_q, opb_q, res_q;
  logic [XLEN-1:0]   div_quo_q, div_rem_q, div_dvs_q;
  logic              neg_q_q, neg_r_q;

  // Multiplier: both operands sign- or zero-extended to 2*XLEN so one unsigned
  // product yields the correct low and high halves for every MUL* flavour.
  logic              mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
  logic [XLEN-1:0]   mul_res;

  assign mul_sa    = !cur_op_q[2] && ((cur_op_q[1:0] == 2'd1) || (cur_op_q[1:0] == 2'd2));
  assign mul_sb    = !cur_op_q[2] && (cur_op_q[1:0] == 2'd1);
  assign mul_a_ext = {{XLEN{mul_sa & opa_q[XLEN-1]}}, opa_q};
  assign mul_b_ext = {{XLEN{mul_sb & opb_q[XLEN-1]}}, opb_q};
  assign mul_prod  = mul_a_ext * mul_b_ext;
  assign mul_res   = (cur_op_q[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Restoring divider step: shift the next dividend bit into the partial
  // remainder, subtract the divisor, keep the difference if it did not borrow.
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_n, quo_n, q_out, r_out, div_res;

  assign rem_sh   = {div_rem_q, div_quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, div_dvs_q};
  assign rem_ge   = !rem_diff[XLEN];
  assign rem_n    = rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_n    = {div_quo_q[XLEN-2:0], rem_ge};
  assign q_out    = neg_q_q ? (XLEN'(0) - quo_n) : quo_n;
  assign r_out    = neg_r_q ? (XLEN'(0) - rem_n) : rem_n;
  assign div_res  = cur_op_q[1] ? r_out : q_out;

  // Operand latch at pop, iteration counter, divider registers and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_op_q   <= '0;
      cur_hart_q <= '0;
      cur_rd_q   <= '0;
      cnt_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      div_quo_q  <= '0;
      div_rem_q  <= '0;
      div_dvs_q  <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      res_q      <= '0;
    end else if (latch) begin
      cur_op_q   <= h_op;
      cur_hart_q <= h_hart;
      cur_rd_q   <= h_rd;
      cnt_q      <= '0;
      opa_q      <= h_a;
      opb_q      <= h_b;
      div_quo_q  <= h_a_abs;
      div_rem_q  <= '0;
      div_dvs_q  <= h_b_abs;
      // Quotient is negative when signs differ; remainder takes the dividend's sign.
      neg_q_q    <= h_signed_div && (h_a[XLEN-1] ^ h_b[XLEN-1]);
      neg_r_q    <= h_signed_div && h_a[XLEN-1];
      if (h_special) res_q <= h_spec_res;
    end else begin
      if ((state_q == ST_MUL) || (state_q == ST_DIV)) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == ST_DIV) begin
        div_quo_q <= quo_n;
        div_rem_q <= rem_n;
      end
      if (mul_last && !kill_cur) res_q <= mul_res;
      if (div_last && !kill_cur) res_q <= div_res;
    end
  end

  // A done coinciding with a kill of the same hart is suppressed.
  assign muldiv_done         = (state_q == ST_DONE) && !kill_cur;
  assign muldiv_result       = res_q;
  assign muldiv_done_hart_id = cur_hart_q;
  assign muldiv_done_rd      = cur_rd_q;

endmodule

// File: tb/tb_muldiv_unit_mq.sv
// Self-checking bench for muldiv_unit_mq: directed RV32M cases, latency,
// back-pressure, per-hart kill, mid-operation reset and a random mix checked
// against a behavioural reference.
module tb_muldiv_unit_mq;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic        muldiv_start;
  logic [2:0]  muldiv_op;
  logic [31:0] muldiv_a, muldiv_b;
  logic        muldiv_hart_id;
  logic [4:0]  muldiv_rd;
  logic        muldiv_kill;
  logic        muldiv_kill_hart_id;
  logic        muldiv_busy, muldiv_done;
  logic [31:0] muldiv_result;
  logic        muldiv_done_hart_id;
  logic [4:0]  muldiv_done_rd;

  muldiv_unit_mq #(.XLEN(32), .HART_ID_W(1), .REG_ADDR_W(5), .QDEPTH(4), .MUL_LAT(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .muldiv_start        (muldiv_start),
    .muldiv_op           (muldiv_op),
    .muldiv_a            (muldiv_a),
    .muldiv_b            (muldiv_b),
    .muldiv_hart_id      (muldiv_hart_id),
    .muldiv_rd           (muldiv_rd),
    .muldiv_kill         (muldiv_kill),
    .muldiv_kill_hart_id (muldiv_kill_hart_id),
    .muldiv_busy         (muldiv_busy),
    .muldiv_done         (muldiv_done),
    .muldiv_result       (muldiv_result),
    .muldiv_done_hart_id (muldiv_done_hart_id),
    .muldiv_done_rd      (muldiv_done_rd)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [37:0] exp_q[$];   // {hart, rd, result}
  int last_done_cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every completion against the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && muldiv_done === 1'b1) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0)
        check_val("spurious_done", 64'(muldiv_done), 64'(0));
      else
        check_val("done", {muldiv_done_hart_id, muldiv_done_rd, muldiv_result}, exp_q.pop_front());
    end
  end

  // Behavioural RV32M reference
  function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    int ia, ib;
    logic ovf;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    ia = $signed(a); ib = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ref_fn = '0;
    case (op)
      3'd0: ref_fn = a * b;
      3'd1: begin p = sa * sb; ref_fn = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); ref_fn = p[63:32]; end
      3'd3: begin pu = ua * ub; ref_fn = pu[63:32]; end
      3'd4: ref_fn = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      3'd5: ref_fn = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_fn = (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      default: ref_fn = (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds the request across exactly one rising edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic h, input logic [4:0] rd, input logic [31:0] exp, input bit do_push);
    muldiv_start   = 1'b1;
    muldiv_op      = op;
    muldiv_a       = a;
    muldiv_b       = b;
    muldiv_hart_id = h;
    muldiv_rd      = rd;
    if (do_push) exp_q.push_back({h, rd, exp});
    @(negedge clk);
    muldiv_start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_val("drain", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  int t0;

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    muldiv_start = 1'b0; muldiv_op = '0; muldiv_a = '0; muldiv_b = '0;
    muldiv_hart_id = 1'b0; muldiv_rd = '0; muldiv_kill = 1'b0; muldiv_kill_hart_id = 1'b0;
    #1;
    check_val("rst_busy", 64'(muldiv_busy), 0);
    check_val("rst_done", 64'(muldiv_done), 0);
    check_val("rst_result", 64'(muldiv_result), 0);
    check_val("rst_hart", 64'(muldiv_done_hart_id), 0);
    check_val("rst_rd", 64'(muldiv_done_rd), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back MUL, DIV, REM in order
    send(3'd0, 32'd10, 32'd3, 1'b0, 5'd3, 32'd30, 1);
    send(3'd4, 32'd10, 32'd3, 1'b0, 5'd4, 32'd3, 1);
    send(3'd6, 32'd10, 32'd3, 1'b0, 5'd5, 32'd1, 1);
    wait_drain(200);

    // High-half multiplies
    send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd6, 32'h0, 1);
    send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd7, 32'hFFFF_FFFE, 1);
    send(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd8, 32'hFFFF_FFFF, 1);
    wait_drain(100);

    // MUL latency from pop (idle, empty unit)
    send(3'd0, 32'd6, 32'd7, 1'b0, 5'd1, 32'd42, 1);
    t0 = cyc;
    wait_drain(100);
    check_val("lat_mul", 64'(last_done_cyc - t0), 64'(3));

    // Divide special cases
    send(3'd4, 32'd7, 32'd0, 1'b0, 5'd9, 32'hFFFF_FFFF, 1);
    wait_drain(100);
    send(3'd7, 32'd7, 32'd0, 1'b0, 5'd10, 32'd7, 1);
    wait_drain(100);
    send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd11, 32'h8000_0000, 1);
    t0 = cyc;
    wait_drain(100);
    check_val("lat_ovf", 64'(last_done_cyc - t0), 64'(1));

    // Signed truncating division and its latency
    send(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd12, 32'hFFFF_FFFD, 1);
    t0 = cyc;
    wait_drain(100);
    check_val("lat_div", 64'(last_done_cyc - t0), 64'(XLEN + 1));
    send(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd13, 32'hFFFF_FFFF, 1);
    wait_drain(100);

    // Back-pressure: DIV in flight, then 5 consecutive starts, the 5th is dropped
    send(3'd5, 32'd1000, 32'd7, 1'b0, 5'd1, 32'd142, 1);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      send(3'd0, 32'(k), 32'd5, 1'b1, 5'(k + 16), 32'(k * 5), k <= 4);
      check_val($sformatf("busy_%0d", k), 64'(muldiv_busy), 64'(k >= 4));
    end
    wait_drain(400);
    check_val("busy_release", 64'(muldiv_busy), 0);

    // Per-hart kill: in-flight and queued hart0 work vanishes, hart1 survives,
    // a hart0 start in the kill cycle is still accepted
    send(3'd4, 32'd100, 32'd9, 1'b0, 5'd20, 32'd0, 0);
    send(3'd0, 32'd11, 32'd12, 1'b1, 5'd21, 32'd132, 1);
    send(3'd5, 32'd50, 32'd5, 1'b0, 5'd22, 32'd0, 0);
    repeat (3) @(negedge clk);
    muldiv_kill = 1'b1;
    muldiv_kill_hart_id = 1'b0;
    send(3'd0, 32'd9, 32'd9, 1'b0, 5'd23, 32'd81, 1);
    muldiv_kill = 1'b0;
    wait_drain(200);
    repeat (40) @(negedge clk);

    // Reset in the middle of a divide
    send(3'd4, 32'd12345, 32'd67, 1'b1, 5'd24, 32'd0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_done", 64'(muldiv_done), 0);
    check_val("midrst_result", 64'(muldiv_result), 0);
    check_val("midrst_busy", 64'(muldiv_busy), 0);
    check_val("midrst_rd", 64'(muldiv_done_rd), 0);
    check_val("midrst_hart", 64'(muldiv_done_hart_id), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'd0, 32'd6, 32'd7, 1'b1, 5'd25, 32'd42, 1);
    t0 = cyc;
    wait_drain(100);
    check_val("lat_after_rst", 64'(last_done_cyc - t0), 64'(3));

    // Random mix against the reference model
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        h;
      int          n;
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      h  = 1'($urandom_range(0, 1));
      n  = 0;
      while (muldiv_busy === 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) check_val("busy_timeout", 64'(muldiv_busy), 0);
      send(op, a, b, h, 5'($urandom_range(0, 31)), ref_fn(op, a, b), 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
